// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Owns the single write port of the register file and shares it
//            between two writeback requesters, A (ALU result) and B (load
//            data).
//
//            After reset an optional clear sweep writes zero to every
//            register. The register file has no contents reset, so this
//            sweep is what initialises it.
//
//            Once the sweep is done, A and B are arbitrated round-robin over
//            valid/ready handshakes. Writes to x0 are accepted but dropped.
//
//            The write outputs are registered and drive the register file
//            inputs directly.
//
// Ports    : clk, reset              clock, synchronous active-high reset
//            a_valid/a_ready/a_rd/a_data   requester A handshake + payload
//            b_valid/b_ready/b_rd/b_data   requester B handshake + payload
//            RegWrite/RD/WriteData   registered register-file write port
//            init_done               clear sweep complete, requesters served
//
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int XLEN           = 64,
  parameter int NUM_REGS       = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [$clog2(NUM_REGS)-1:0] a_rd,
  input  logic [XLEN-1:0]             a_data,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [$clog2(NUM_REGS)-1:0] b_rd,
  input  logic [XLEN-1:0]             b_data,
  output logic                        RegWrite,
  output logic [$clog2(NUM_REGS)-1:0] RD,
  output logic [XLEN-1:0]             WriteData,
  output logic                        init_done
);

  localparam int RD_W = $clog2(NUM_REGS);

  // Index of the final register issued by the clear sweep.
  localparam logic [RD_W-1:0] C_LAST_IDX = RD_W'(NUM_REGS - 1);

  // last_grant encoding
  localparam logic C_GRANT_A = 1'b0;
  localparam logic C_GRANT_B = 1'b1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_next;
  logic [RD_W-1:0]   r_clr_idx;
  logic              r_last_grant;
  logic              r_init_done;
  logic              r_regwrite;
  logic [RD_W-1:0]   r_rd;
  logic [XLEN-1:0]   r_wdata;

  // --------------------------------------------------------------------------
  // Combinational grant / next-state
  // --------------------------------------------------------------------------
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_xfer;
  logic              w_winner;
  logic [RD_W-1:0]   w_win_rd;
  logic [XLEN-1:0]   w_win_data;
  logic              w_clr_last;

  assign w_clr_last = (r_clr_idx == C_LAST_IDX);

  always_comb begin
    w_state_next = r_state;
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;

    case (r_state)
      ST_CLEAR: begin
        // Requesters are held off for the whole sweep.
        if (w_clr_last) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (a_valid && b_valid) begin
          // Contention: serve whichever requester did not win last time.
          w_grant_a = (r_last_grant == C_GRANT_B);
          w_grant_b = (r_last_grant == C_GRANT_A);
        end else begin
          w_grant_a = a_valid;
          w_grant_b = b_valid;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase

    // Reset overrides everything: nothing is accepted in the reset cycle.
    if (reset) begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
    end
  end

  // Grants already require valid, so a grant is a transfer.
  assign w_xfer     = w_grant_a | w_grant_b;
  assign w_winner   = w_grant_b ? C_GRANT_B : C_GRANT_A;
  assign w_win_rd   = w_grant_b ? b_rd   : a_rd;
  assign w_win_data = w_grant_b ? b_data : a_data;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Sweep counter, arbitration history and registered write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regwrite   <= 1'b0;
      r_rd         <= '0;
      r_wdata      <= '0;
      r_clr_idx    <= '0;
      r_last_grant <= C_GRANT_B;
      r_init_done  <= (CLEAR_ON_RESET == 0);
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_regwrite <= 1'b1;
          r_rd       <= r_clr_idx;
          r_wdata    <= '0;
          r_clr_idx  <= r_clr_idx + 1'b1;
          if (w_clr_last) begin
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_last_grant <= w_winner;
            r_rd         <= w_win_rd;
            r_wdata      <= w_win_data;
            // x0 is hard-wired zero: consume the write but never commit it.
            r_regwrite   <= (w_win_rd != '0);
          end else begin
            // RD/WriteData hold so the port only toggles on real writes.
            r_regwrite   <= 1'b0;
          end
        end
        default: begin
          r_regwrite <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;
  assign RegWrite  = r_regwrite;
  assign RD        = r_rd;
  assign WriteData = r_wdata;
  assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter. Instance
//            u_dut uses the clear sweep; u_dut_nc has CLEAR_ON_RESET=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int XLEN = 64;

  logic            clk;
  logic            reset;
  logic            a_valid, b_valid;
  logic            a_ready, b_ready;
  logic [4:0]      a_rd, b_rd;
  logic [XLEN-1:0] a_data, b_data;
  logic            RegWrite;
  logic [4:0]      RD;
  logic [XLEN-1:0] WriteData;
  logic            init_done;

  logic            reset_nc;
  logic            a_valid_nc, b_valid_nc;
  logic            a_ready_nc, b_ready_nc;
  logic [4:0]      a_rd_nc, b_rd_nc;
  logic [XLEN-1:0] a_data_nc, b_data_nc;
  logic            RegWrite_nc;
  logic [4:0]      RD_nc;
  logic [XLEN-1:0] WriteData_nc;
  logic            init_done_nc;

  int n_checks;
  int n_pass;

  regfile_wb_arbiter #(.XLEN(XLEN), .NUM_REGS(32), .CLEAR_ON_RESET(1)) u_dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData), .init_done(init_done)
  );

  regfile_wb_arbiter #(.XLEN(XLEN), .NUM_REGS(32), .CLEAR_ON_RESET(0)) u_dut_nc (
    .clk(clk), .reset(reset_nc),
    .a_valid(a_valid_nc), .a_ready(a_ready_nc), .a_rd(a_rd_nc), .a_data(a_data_nc),
    .b_valid(b_valid_nc), .b_ready(b_ready_nc), .b_rd(b_rd_nc), .b_data(b_data_nc),
    .RegWrite(RegWrite_nc), .RD(RD_nc), .WriteData(WriteData_nc), .init_done(init_done_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return just after the edge so registered outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check one clear-sweep write, issued at the edge just taken.
  task automatic chk_sweep(input int i);
    chk("clr_we",   RegWrite, 1);
    chk("clr_rd",   RD, i);
    chk("clr_data", WriteData, 0);
    chk("clr_done", init_done, (i == 31) ? 1 : 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    a_valid = 1'b1; a_rd = 5'd1; a_data = 64'h1;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 64'h2;
    reset_nc = 1'b1;
    a_valid_nc = 1'b0; a_rd_nc = '0; a_data_nc = '0;
    b_valid_nc = 1'b0; b_rd_nc = '0; b_data_nc = '0;

    // ---- 1. reset state, then clear sweep with both valids asserted ----
    step(); step();
    chk("rst_we",    RegWrite, 0);
    chk("rst_rd",    RD, 0);
    chk("rst_data",  WriteData, 0);
    chk("rst_done",  init_done, 0);
    chk("rst_aready", a_ready, 0);
    chk("rst_bready", b_ready, 0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("clr_aready", a_ready, 0);
      chk("clr_bready", b_ready, 0);
      step();
      chk_sweep(i);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // ---- 3. contention alternates A,B,A,B starting with A ----
    step();
    chk("idle_we", RegWrite, 0);
    a_valid = 1'b1; a_rd = 5'd1; a_data = 64'hA;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 64'hB;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_aready", a_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_bready", b_ready, (k % 2 == 1) ? 1 : 0);
      step();
      chk("rr_we",   RegWrite, 1);
      chk("rr_rd",   RD, (k % 2 == 0) ? 1 : 2);
      chk("rr_data", WriteData, (k % 2 == 0) ? 64'hA : 64'hB);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    chk("rr_idle_we", RegWrite, 0);

    // ---- 2. single A write, latency and hold of RD/WriteData ----
    a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h1234;
    #1;
    chk("a1_aready", a_ready, 1);
    chk("a1_bready", b_ready, 0);
    step();
    a_valid = 1'b0;
    chk("a1_we",   RegWrite, 1);
    chk("a1_rd",   RD, 5);
    chk("a1_data", WriteData, 64'h1234);
    step();
    chk("a1_we_off",  RegWrite, 0);
    chk("a1_rd_hold", RD, 5);
    chk("a1_data_hold", WriteData, 64'h1234);

    // Single B write so last_grant becomes B before the x0 test.
    b_valid = 1'b1; b_rd = 5'd9; b_data = 64'h99;
    #1;
    chk("b1_bready", b_ready, 1);
    step();
    b_valid = 1'b0;
    chk("b1_rd",   RD, 9);
    chk("b1_data", WriteData, 64'h99);

    // ---- 4. x0 write dropped but still updates last_grant ----
    a_valid = 1'b1; a_rd = 5'd0; a_data = 64'hFF;
    #1;
    chk("x0_aready", a_ready, 1);
    step();
    a_valid = 1'b0;
    chk("x0_we", RegWrite, 0);
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'h33;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 64'h44;
    #1;
    chk("x0_cont_aready", a_ready, 0);
    chk("x0_cont_bready", b_ready, 1);
    step();
    b_valid = 1'b0;
    chk("x0_cont_we",   RegWrite, 1);
    chk("x0_cont_rd",   RD, 4);
    chk("x0_cont_data", WriteData, 64'h44);

    // ---- reset in RUN drops the pending write; no accept during reset ----
    // A is still valid (rd=3) and is accepted here.
    step();
    chk("pend_we", RegWrite, 1);
    chk("pend_rd", RD, 3);
    reset = 1'b1;
    #1;
    chk("runrst_aready", a_ready, 0);
    step();
    a_valid = 1'b0;
    chk("runrst_we",   RegWrite, 0);
    chk("runrst_done", init_done, 0);

    // ---- 5. reset mid-sweep at RD=10 restarts the sweep ----
    reset = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      step();
      chk_sweep(i);
    end
    reset = 1'b1;
    step();
    chk("midrst_we",   RegWrite, 0);
    chk("midrst_done", init_done, 0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      chk_sweep(i);
    end

    // ---- 6. CLEAR_ON_RESET=0 serves B immediately after reset ----
    b_valid_nc = 1'b1; b_rd_nc = 5'd7; b_data_nc = 64'h55;
    #1;
    chk("nc_rst_bready", b_ready_nc, 0);
    chk("nc_rst_done",   init_done_nc, 1);
    chk("nc_rst_we",     RegWrite_nc, 0);
    reset_nc = 1'b0;
    #1;
    chk("nc_bready", b_ready_nc, 1);
    chk("nc_aready", a_ready_nc, 0);
    step();
    b_valid_nc = 1'b0;
    chk("nc_we",   RegWrite_nc, 1);
    chk("nc_rd",   RD_nc, 7);
    chk("nc_data", WriteData_nc, 64'h55);
    chk("nc_done", init_done_nc, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
